// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds two WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, carry held in a register between chunks.
// Handshake: start_i accepted in IDLE; busy_o high for N=WIDTH/CHUNK
// cycles, then a one-cycle done_o pulse with sum_o/cout_o updated.
// Ports: clk_i, rst_i (sync, active-high), start_i, a_i, b_i, cin_i,
//   sub_i (only with SERIAL_ADDER_SUB_EN), busy_o, done_o, sum_o, cout_o.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds sub_i (a - b mode).
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
      $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [CHUNK:0]   chunk_s;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             last;

  // Subtraction is a + ~b + 1, so it only changes what gets latched.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub_i ? ~b_i : b_i;
  assign c_load = sub_i ? 1'b1 : cin_i;
`else
  assign b_load = b_i;
  assign c_load = cin_i;
`endif

  assign chunk_s = {1'b0, a_q[CHUNK-1:0]}
                 + {1'b0, b_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};

  // New chunk enters at the MSB end; after N shifts the
  // first chunk has reached bit 0.
  assign res_shift = (res_q >> CHUNK)
                   | (WIDTH'(chunk_s[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign last = (idx_q == IW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_load;
          carry_d = c_load;
          res_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift;
        carry_d = chunk_s[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (last) begin
          sum_d  = res_shift;
          cout_d = chunk_s[CHUNK];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK=2, 8, 1) on
// shared inputs, vector table + random ops vs. an arithmetic model.
module tb_serial_chunk_adder;

  logic       clk = 1'b0;
  logic       rst, start, cin, sub;
  logic [7:0] a, b;

  logic       busy_w[3], done_w[3], cout_w[3];
  logic [7:0] sum_w[3];
  logic [7:0] prev_s[3];
  logic       prev_c[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_i(a), .b_i(b), .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[0]), .done_o(done_w[0]),
    .sum_o(sum_w[0]), .cout_o(cout_w[0])
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_i(a), .b_i(b), .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[1]), .done_o(done_w[1]),
    .sum_o(sum_w[1]), .cout_o(cout_w[1])
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_i(a), .b_i(b), .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[2]), .done_o(done_w[2]),
    .sum_o(sum_w[2]), .cout_o(cout_w[2])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t tbl[$];

  function automatic int nchunks(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  // Result as the plain arithmetic of the operation.
  function automatic logic [8:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic c,
                                       input logic s);
    logic [8:0] r;
    if (s) begin
      r[7:0] = x - y;
      r[8]   = (x >= y);
    end else begin
      r = 9'(x) + 9'(y) + 9'(c);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_prev();
    for (int i = 0; i < 3; i++) begin
      prev_s[i] = 8'h00;
      prev_c[i] = 1'b0;
    end
  endtask

  task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vs,
                       input logic [7:0] es, input logic ec,
                       input string tag);
    int         bc[3], dc[3], dcyc[3];
    logic [7:0] gs[3];
    logic       gc[3], held[3];
    for (int i = 0; i < 3; i++) begin
      bc[i] = 0; dc[i] = 0; dcyc[i] = 0;
      gs[i] = 8'h00; gc[i] = 1'b0; held[i] = 1'b1;
    end
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bc[i]++;
        if (done_w[i]) begin
          dc[i]++; dcyc[i] = k;
          gs[i] = sum_w[i]; gc[i] = cout_w[i];
          prev_s[i] = es; prev_c[i] = ec;
        end else if (sum_w[i] !== prev_s[i] ||
                     cout_w[i] !== prev_c[i]) begin
          held[i] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/u%0d busy_cycles", tag, i), bc[i], nchunks(i));
      chk($sformatf("%s/u%0d done_cycle", tag, i), dcyc[i], nchunks(i) + 1);
      chk($sformatf("%s/u%0d done_count", tag, i), dc[i], 1);
      chk($sformatf("%s/u%0d sum", tag, i), gs[i], es);
      chk($sformatf("%s/u%0d cout", tag, i), gc[i], ec);
      chk($sformatf("%s/u%0d held", tag, i), held[i], 1);
    end
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb, s5, s11;
    logic       rc, rs, c5, c11;
    int         dcnt, dcyc;

    rst = 1'b1; start = 1'b0; cin = 1'b0; sub = 1'b0;
    a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset/u%0d busy", i), busy_w[i], 0);
      chk($sformatf("reset/u%0d done", i), done_w[i], 0);
      chk($sformatf("reset/u%0d sum", i), sum_w[i], 0);
      chk($sformatf("reset/u%0d cout", i), cout_w[i], 0);
    end
    rst = 1'b0;
    clr_prev();
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", busy_w[0], 0);
    chk("idle done", done_w[0], 0);

    tbl.push_back('{a:8'h0F, b:8'h01, cin:0, sub:0, es:8'h10, ec:0});
    tbl.push_back('{a:8'hFF, b:8'h01, cin:0, sub:0, es:8'h00, ec:1});
    tbl.push_back('{a:8'hFF, b:8'hFF, cin:1, sub:0, es:8'hFF, ec:1});
    tbl.push_back('{a:8'h00, b:8'h00, cin:1, sub:0, es:8'h01, ec:0});
    tbl.push_back('{a:8'h80, b:8'h80, cin:0, sub:0, es:8'h00, ec:1});
    tbl.push_back('{a:8'h7F, b:8'h00, cin:1, sub:0, es:8'h80, ec:0});
    tbl.push_back('{a:8'hAA, b:8'h55, cin:0, sub:0, es:8'hFF, ec:0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{a:8'h05, b:8'h07, cin:0, sub:1, es:8'hFE, ec:0});
    tbl.push_back('{a:8'h07, b:8'h05, cin:0, sub:1, es:8'h02, ec:1});
    tbl.push_back('{a:8'h05, b:8'h05, cin:0, sub:1, es:8'h00, ec:1});
    tbl.push_back('{a:8'h00, b:8'h01, cin:1, sub:1, es:8'hFF, ec:0});
`endif
    foreach (tbl[j]) begin
      do_op(tbl[j].a, tbl[j].b, tbl[j].cin, tbl[j].sub,
            tbl[j].es, tbl[j].ec, $sformatf("vec%0d", j));
    end

    for (int j = 0; j < 30; j++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, r[7:0], r[8], $sformatf("rnd%0d", j));
    end

    // start held through RUN/DONE with operands changing
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h55; b = 8'h22;
    dcnt = 0; s5 = 8'h00; c5 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (done_w[0]) begin
        dcnt++; s5 = sum_w[0]; c5 = cout_w[0];
      end
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("held_start done_count", dcnt, 1);
    chk("held_start sum1", s5, 8'h10);
    chk("held_start cout1", c5, 0);
    @(posedge clk); #1;
    chk("held_start idle busy", busy_w[0], 0);
    chk("held_start idle done", done_w[0], 0);
    @(posedge clk); #1;
    chk("held_start rerun busy", busy_w[0], 1);
    start = 1'b0;
    dcnt = 0; dcyc = 0; s11 = 8'h00; c11 = 1'b1;
    for (int k = 7; k <= 14; k++) begin
      if (done_w[0]) begin
        dcnt++; dcyc = k; s11 = sum_w[0]; c11 = cout_w[0];
      end
      @(posedge clk); #1;
    end
    chk("held_start done2_count", dcnt, 1);
    chk("held_start done2_cycle", dcyc, 11);
    chk("held_start sum2", s11, 8'h77);
    chk("held_start cout2", c11, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset in the second RUN cycle aborts the operation
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort/u%0d busy", i), busy_w[i], 0);
      chk($sformatf("abort/u%0d done", i), done_w[i], 0);
      chk($sformatf("abort/u%0d sum", i), sum_w[i], 0);
      chk($sformatf("abort/u%0d cout", i), cout_w[i], 0);
    end
    clr_prev();
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (done_w[i] || busy_w[i]) dcnt++;
      end
      @(posedge clk); #1;
    end
    chk("abort no_activity", dcnt, 0);

    // reset and start on the same edge: reset wins
    a = 8'h01; b = 8'h01; rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", busy_w[0], 0);
    @(posedge clk); #1;
    chk("rst_start busy2", busy_w[0], 0);
    chk("rst_start sum", sum_w[0], 0);

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, "post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
